// File: rtl/seq_detect_1101.sv
// ---------------------------------------------------------------------------
// seq_detect_1101
//
// Serial pattern detector for 1101 (MSB first, overlapping). One bit is
// accepted on every clock where bit_valid is high. A Moore FSM and a Mealy
// FSM track the stream side by side, so their detect outputs can be compared:
// the Mealy detect fires in the cycle of the completing bit, while the Moore
// detect follows one cycle later. Also provides a saturating hit counter, a
// 4-bit history of accepted bits, and an inactivity timeout that returns both
// FSMs to their start states.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high, overrides everything
//   bit_valid      accept bit_in on this cycle
//   bit_in         serial data bit
//   moore_det      registered, high while the Moore FSM sits in HIT
//   mealy_det      combinational, high on the bit that completes 1101
//   moore_state    Moore state code (IDLE=0 .. HIT=4)
//   mealy_state    Mealy state code (M0=0 .. M110=3)
//   hit_count      number of Mealy detections, saturating
//   history        last four accepted bits, bit0 newest
//   timeout_pulse  registered one-cycle pulse when the idle timeout fires
// ---------------------------------------------------------------------------
module seq_detect_1101 #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 500000000,
    parameter int TMR_W       = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             moore_det,
    output logic             mealy_det,
    output logic [2:0]       moore_state,
    output logic [1:0]       mealy_state,
    output logic [CNT_W-1:0] hit_count,
    output logic [3:0]       history,
    output logic             timeout_pulse
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        G1   = 3'd1,
        G11  = 3'd2,
        G110 = 3'd3,
        HIT  = 3'd4
    } moore_t;

    typedef enum logic [1:0] {
        M0   = 2'd0,
        M1   = 2'd1,
        M11  = 2'd2,
        M110 = 2'd3
    } mealy_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    moore_t           moore_q, moore_d;
    mealy_t           mealy_q, mealy_d;
    logic             moore_det_q, moore_det_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [3:0]       hist_q, hist_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             expire;

    function automatic moore_t moore_next(input moore_t s, input logic b);
        moore_t n;
        n = IDLE;
        case (s)
            IDLE:    n = b ? G1  : IDLE;
            G1:      n = b ? G11 : IDLE;
            G11:     n = b ? G11 : G110;
            G110:    n = b ? HIT : IDLE;
            HIT:     n = b ? G11 : IDLE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic mealy_t mealy_next(input mealy_t s, input logic b);
        mealy_t n;
        n = M0;
        case (s)
            M0:   n = b ? M1  : M0;
            M1:   n = b ? M11 : M0;
            M11:  n = b ? M11 : M110;
            M110: n = b ? M1  : M0;
            default: n = M0;
        endcase
        return n;
    endfunction

    // Not gated by rst: the detect is a pure decode of the current inputs.
    assign mealy_det = bit_valid & bit_in & (mealy_q == M110);

    // A valid bit on the expiry cycle wins over the timeout.
    assign expire = !bit_valid && (timer_q == TMR_LAST);

    always_comb begin
        moore_d  = moore_q;
        mealy_d  = mealy_q;
        hits_d   = hits_q;
        hist_d   = hist_q;
        timer_d  = timer_q;

        if (bit_valid) begin
            moore_d = moore_next(moore_q, bit_in);
            mealy_d = mealy_next(mealy_q, bit_in);
            hist_d  = {hist_q[2:0], bit_in};
            timer_d = '0;
            if (mealy_det && (hits_q != CNT_MAX)) begin
                hits_d = hits_q + 1'b1;
            end
        end else if (expire) begin
            moore_d = IDLE;
            mealy_d = M0;
            timer_d = '0;
        end else begin
            // Illegal Moore codes recover even without input activity.
            if (!(moore_q inside {IDLE, G1, G11, G110, HIT})) begin
                moore_d = IDLE;
            end
            if ((moore_q == IDLE) && (mealy_q == M0)) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        moore_det_d = (moore_d == HIT);
        timeout_d   = expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            moore_q     <= IDLE;
            mealy_q     <= M0;
            moore_det_q <= 1'b0;
            timeout_q   <= 1'b0;
            hits_q      <= '0;
            hist_q      <= '0;
            timer_q     <= '0;
        end else begin
            moore_q     <= moore_d;
            mealy_q     <= mealy_d;
            moore_det_q <= moore_det_d;
            timeout_q   <= timeout_d;
            hits_q      <= hits_d;
            hist_q      <= hist_d;
            timer_q     <= timer_d;
        end
    end

    assign moore_det     = moore_det_q;
    assign moore_state   = moore_q;
    assign mealy_state   = mealy_q;
    assign hit_count     = hits_q;
    assign history       = hist_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_seq_detect_1101.sv
module tb_seq_detect_1101;

    logic       clk;
    logic       rst;
    logic       bit_valid;
    logic       bit_in;
    logic       moore_det;
    logic       mealy_det;
    logic [2:0] moore_state;
    logic [1:0] mealy_state;
    logic [1:0] hit_count;
    logic [3:0] history;
    logic       timeout_pulse;

    int   checks = 0;
    int   errors = 0;
    logic mdet_s;

    seq_detect_1101 #(
        .CNT_W      (2),
        .TIMEOUT_CYC(16),
        .TMR_W      (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .moore_det    (moore_det),
        .mealy_det    (mealy_det),
        .moore_state  (moore_state),
        .mealy_state  (mealy_state),
        .hit_count    (hit_count),
        .history      (history),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       r;
        logic       bv;
        logic       bi;
        logic       ex_mealy;
        logic [2:0] ex_ms;
        logic [1:0] ex_me;
        logic       ex_moore;
        logic [1:0] ex_hits;
        logic [3:0] ex_hist;
        logic       ex_to;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Drive inputs for one cycle; mealy_det is sampled mid-cycle, registered
    // outputs are sampled 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic bv, input logic bi);
        rst       = r;
        bit_valid = bv;
        bit_in    = bi;
        @(negedge clk);
        mdet_s = mealy_det;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;

        // reset, overlap stream 1101(idle)101 then 0
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 2'd1, 1'b0, 2'd0, 4'b0001, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 2'd2, 1'b0, 2'd0, 4'b0011, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 2'd3, 1'b0, 2'd0, 4'b0110, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 2'd1, 1'b1, 2'd1, 4'b1101, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 2'd1, 1'b1, 2'd1, 4'b1101, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 2'd2, 1'b0, 2'd1, 4'b1011, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 2'd3, 1'b0, 2'd1, 4'b0110, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 2'd1, 1'b1, 2'd2, 4'b1101, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd2, 4'b1010, 1'b0};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].r, tbl[i].bv, tbl[i].bi);
            chk($sformatf("tbl%0d mealy_det", i), mdet_s, tbl[i].ex_mealy);
            chk($sformatf("tbl%0d moore_state", i), moore_state, tbl[i].ex_ms);
            chk($sformatf("tbl%0d mealy_state", i), mealy_state, tbl[i].ex_me);
            chk($sformatf("tbl%0d moore_det", i), moore_det, tbl[i].ex_moore);
            chk($sformatf("tbl%0d hit_count", i), hit_count, tbl[i].ex_hits);
            chk($sformatf("tbl%0d history", i), history, tbl[i].ex_hist);
            chk($sformatf("tbl%0d timeout_pulse", i), timeout_pulse, tbl[i].ex_to);
        end

        // Single detection, one pulse every 5 cycles
        begin
            logic bits [4];
            do_reset();
            bits[0] = 1'b1; bits[1] = 1'b1; bits[2] = 1'b0; bits[3] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                cyc(1'b0, 1'b1, bits[b]);
                chk($sformatf("single bit%0d mealy_det", b), mdet_s, (b == 3) ? 1 : 0);
                chk($sformatf("single bit%0d moore_det", b), moore_det, (b == 3) ? 1 : 0);
                for (int k = 0; k < 4; k++) begin
                    cyc(1'b0, 1'b0, 1'b0);
                    chk($sformatf("single gap%0d.%0d moore_det", b, k), moore_det, (b == 3) ? 1 : 0);
                end
            end
            chk("single hit_count", hit_count, 1);
            chk("single history", history, 4'b1101);
            cyc(1'b0, 1'b1, 1'b0);
            chk("single next moore_det", moore_det, 0);
            chk("single next moore_state", moore_state, 0);
        end

        // Timeout after bits 1,1
        do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (k < 16) begin
                chk($sformatf("tmo idle%0d pulse", k), timeout_pulse, 0);
                chk($sformatf("tmo idle%0d moore_state", k), moore_state, 2);
            end else begin
                chk("tmo fire pulse", timeout_pulse, 1);
                chk("tmo fire moore_state", moore_state, 0);
                chk("tmo fire mealy_state", mealy_state, 0);
                chk("tmo fire history", history, 4'b0011);
                chk("tmo fire hit_count", hit_count, 0);
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("tmo pulse width", timeout_pulse, 0);

        // Bit arriving on the expiry cycle beats the timeout
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
        end
        chk("race pre pulse", timeout_pulse, 0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("race pulse", timeout_pulse, 0);
        chk("race moore_state", moore_state, 2);
        chk("race mealy_state", mealy_state, 2);
        cyc(1'b0, 1'b0, 1'b0);
        chk("race after pulse", timeout_pulse, 0);
        chk("race after moore_state", moore_state, 2);

        // Saturation: 1101101101101101 gives five overlapping detections
        begin
            int   ndet;
            logic bi;
            do_reset();
            ndet = 0;
            for (int i = 0; i < 16; i++) begin
                bi = (i == 0) ? 1'b1 : (((i - 1) % 3) != 1);
                cyc(1'b0, 1'b1, bi);
                if (i > 0 && (i % 3) == 0) ndet++;
                chk($sformatf("sat bit%0d mealy_det", i), mdet_s, (i > 0 && (i % 3) == 0) ? 1 : 0);
                chk($sformatf("sat bit%0d hit_count", i), hit_count, (ndet > 3) ? 3 : ndet);
            end
            chk("sat final moore_state", moore_state, 4);
        end

        // Reset mid-pattern with a completing bit presented
        do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("midrst pre mealy_state", mealy_state, 3);
        cyc(1'b1, 1'b1, 1'b1);
        chk("midrst moore_state", moore_state, 0);
        chk("midrst mealy_state", mealy_state, 0);
        chk("midrst moore_det", moore_det, 0);
        chk("midrst hit_count", hit_count, 0);
        chk("midrst history", history, 0);
        chk("midrst timeout_pulse", timeout_pulse, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("midrst after moore_det", moore_det, 0);
        chk("midrst after hit_count", hit_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_1101.md
Name: seq_detect_1101

Overview:
- Consumes the single-cycle debounced button pulses produced by the push-button debounce stage. Each pulse clocks in one serial bit, taken from a slide switch level.
- Runs a Moore and a Mealy detector for the overlapping pattern 1101 (MSB first) side by side.
- Also keeps a saturating hit counter, a 4-bit input history for the LEDs, and an inactivity timeout that returns both FSMs to their start state.

Parameters:
- CNT_W, 8: width of hit_count.
- TIMEOUT_CYC, 500000000: idle cycles before both FSMs are forced to start (5 s at 100 MHz). Must be >= 2.
- TMR_W, 29: width of the timeout counter. Must satisfy 2^TMR_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high; all state cleared on the clk edge where rst=1.
- bit_valid  in  1  debounced pulse; each cycle it is high consumes one bit.
- bit_in  in  1  serial data bit, sampled only when bit_valid=1.
- moore_det  out  1  registered; 1 while the Moore FSM is in HIT.
- mealy_det  out  1  combinational; bit_valid & bit_in & (mealy_state==M110).
- moore_state  out  3  Moore state code.
- mealy_state  out  2  Mealy state code.
- hit_count  out  CNT_W  number of Mealy detections, saturating.
- history  out  4  last four accepted bits; bit0 is the newest.
- timeout_pulse  out  1  registered; one-cycle pulse when the timeout fires.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: moore_state=IDLE(0), mealy_state=M0(0), hit_count=0, history=0, timer=0, moore_det=0, timeout_pulse=0. mealy_det is 0 unless bit_valid is asserted during reset.
- rst has priority over every other event, including a bit arriving mid-pattern. A bit presented while rst=1 is discarded.
- State changes only on clk edges where bit_valid=1, except for timeout.
- Moore encoding: IDLE=0, G1=1, G11=2, G110=3, HIT=4. Transitions (on bit=1 / bit=0):
  - IDLE: ->G1 / ->IDLE
  - G1: ->G11 / ->IDLE
  - G11: ->G11 / ->G110
  - G110: ->HIT / ->IDLE
  - HIT: ->G11 / ->IDLE
- moore_det=(moore_state==HIT). It rises one cycle after the completing bit and holds until the next accepted bit.
- Mealy encoding: M0=0, M1=1, M11=2, M110=3. Transitions (on bit=1 / bit=0):
  - M0: ->M1 / ->M0
  - M1: ->M11 / ->M0
  - M11: ->M11 / ->M110
  - M110: ->M1 (detect) / ->M0
- mealy_det is high in the same cycle as the completing bit_valid, so it leads moore_det by exactly 1 cycle.
- Overlap: the stream 1101101 yields two detections.
- hit_count increments on the edge where mealy_det=1. It holds at 2^CNT_W-1 and never wraps.
- history shifts on each accepted bit: history <= {history[2:0], bit_in}.
- Timer:
  - Held at 0 while moore_state==IDLE and mealy_state==M0.
  - Otherwise it increments on every cycle with bit_valid=0.
  - Cleared to 0 on any accepted bit.
- Timeout: when the timer equals TIMEOUT_CYC-1 and bit_valid=0, the next edge:
  - sets moore_state=IDLE, mealy_state=M0 and timer=0;
  - pulses timeout_pulse for 1 cycle;
  - leaves history and hit_count unchanged.
- Simultaneous bit_valid and timeout expiry: the bit wins. It is processed normally, the timer clears and no timeout_pulse is generated.
- bit_valid held high for N cycles counts as N bits. Upstream guarantees single-cycle pulses, but the block does not filter.
- Illegal Moore codes 5-7 return to IDLE on the next edge regardless of bit_valid.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release. All outputs 0, moore_state=0, mealy_state=0.
- Single detection: bits 1,1,0,1, one pulse every 5 cycles.
  - mealy_det=1 in the cycle of the 4th pulse; moore_det=1 from the next cycle until the next pulse.
  - hit_count=1, history=4'b1101.
- Overlap: bits 1,1,0,1,1,0,1.
  - Two mealy_det pulses (on the 4th and 7th bits), hit_count=2, final moore_state=4.
  - Then bit 0 gives moore_state=0 and moore_det=0.
- Timeout (TIMEOUT_CYC=16): bits 1,1, then idle.
  - timeout_pulse=1 exactly 16 cycles after the last bit edge; states return to 0/0; history=4'b0011.
  - A repeat with the bit arriving on the expiry cycle gives no timeout_pulse, moore_state=G11, mealy_state=M11.
- Saturation (CNT_W=2): feed 1101 five times (overlapping). hit_count reaches 3 and stays at 3.
- Reset mid-pattern: bits 1,1,0, then rst together with bit_valid=1 and bit_in=1. No detection, and all state is 0 on the following cycle.
